// File: rtl/mem_responder_sram.sv
// mem_responder_sram: word-organised SRAM behind the core's valid/ready memory bus, one request at a time.
// Optional write protection of the lowest PROTECT_WORDS words is built when MEM_RESP_WPROT_EN is defined.
module mem_responder_sram #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned WAIT_STATES   = 0,
  parameter int unsigned PROTECT_WORDS = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_inRange;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [31:0]      w_off;
  logic             w_inRange;
  logic             w_isWrite;
  logic             w_protHit;
  logic             w_latch;
  logic             w_doRead;
  logic             w_doWrite;
  logic             w_accessErr;
  logic [1:0]       w_unusedOffLsb;

  // Offset wraps for addresses below BASE_ADDR, so they land far out of range.
  assign w_off          = mem_addr - BASE_ADDR;
  assign w_inRange      = (w_off[31:IDX_W+2] == '0);
  assign w_unusedOffLsb = w_off[1:0];
  assign w_isWrite      = (r_wstrb != 4'b0000);

`ifdef MEM_RESP_WPROT_EN
  assign w_protHit = w_isWrite && r_inRange && (32'(r_idx) < PROTECT_WORDS);
`else
  localparam int unsigned unusedProtectWords = PROTECT_WORDS;
  assign w_protHit = 1'b0;
`endif

  assign w_accessErr = !r_inRange || w_protHit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid) begin
          w_nextState = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_nextState = ST_ACCESS;
        end
      end
      ST_ACCESS: w_nextState = ST_RESP;
      ST_RESP:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_latch   = 1'b0;
    w_doRead  = 1'b0;
    w_doWrite = 1'b0;
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_latch = mem_valid;
      end
      ST_ACCESS: begin
        w_doRead  = r_inRange && !w_isWrite;
        w_doWrite = r_inRange && w_isWrite && !w_protHit;
      end
      ST_RESP: begin
        mem_ready = 1'b1;
        mem_err   = r_err;
      end
      default: begin
        w_latch = 1'b0;
      end
    endcase
  end

  // Request fields are captured once in IDLE; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_idx     <= w_off[IDX_W+1:2];
      r_inRange <= w_inRange;
      r_wdata   <= mem_wdata;
      r_wstrb   <= mem_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_cnt <= 4'(WAIT_STATES);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ST_ACCESS) begin
        r_rdata <= w_doRead ? r_mem[r_idx] : 32'h0;
        r_err   <= w_accessErr;
      end
    end
  end

  // Reset in the access cycle suppresses the commit.
  always_ff @(posedge clk) begin
    if (resetn && w_doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder_sram.sv
// tb_mem_responder_sram: directed bench for mem_responder_sram with a byte-level memory model.
// Three instances cover 0/3/2 wait states; instance 1 uses a non-zero base and a small depth.
`timescale 1ns/1ps
module tb_mem_responder_sram;

  localparam int NINST = 3;
`ifdef MEM_RESP_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif
  localparam int PROT_WORDS = 16;

  function automatic int depthOf(input int i);
    return (i == 1) ? 64 : 1024;
  endfunction

  function automatic logic [31:0] baseOf(input int i);
    return (i == 1) ? 32'h0000_0100 : 32'h0000_0000;
  endfunction

  function automatic int waitOf(input int i);
    case (i)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rstn  [NINST];
  logic        vld   [NINST];
  logic [31:0] addr  [NINST];
  logic [31:0] wdata [NINST];
  logic [3:0]  wstrb [NINST];
  logic        ready [NINST];
  logic [31:0] rdata [NINST];
  logic        err   [NINST];

  mem_responder_sram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0), .PROTECT_WORDS(PROT_WORDS)) u_d0 (
    .clk(clk), .resetn(rstn[0]), .mem_valid(vld[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_wstrb(wstrb[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_err(err[0]));

  mem_responder_sram #(.DEPTH_WORDS(64), .BASE_ADDR(32'h100), .WAIT_STATES(3), .PROTECT_WORDS(PROT_WORDS)) u_d1 (
    .clk(clk), .resetn(rstn[1]), .mem_valid(vld[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_wstrb(wstrb[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_err(err[1]));

  mem_responder_sram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2), .PROTECT_WORDS(PROT_WORDS)) u_d2 (
    .clk(clk), .resetn(rstn[2]), .mem_valid(vld[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
    .mem_wstrb(wstrb[2]), .mem_ready(ready[2]), .mem_rdata(rdata[2]), .mem_err(err[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Model state: memory image per instance plus the expected response of the pending request.
  logic [31:0] modelMem   [NINST][1024];
  bit          modelKnown [NINST][1024];
  int          expReadyCyc [NINST];
  logic [31:0] expRdata    [NINST];
  logic        expErr      [NINST];
  bit          expKnown    [NINST];
  int          learnIdx    [NINST];
  int          issueCyc    [NINST];
  int          lastReadyCyc[NINST];
  logic [31:0] lastRdata   [NINST];
  logic        lastErr     [NINST];
  bit          checkEn = 1'b0;
  int          checksTotal = 0;
  int          checksPassed = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Every cycle: mem_ready must pulse exactly at the predicted cycle, with matching rdata/err.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < NINST; i++) begin
        logic rdyExp;
        rdyExp = (cyc == expReadyCyc[i]);
        checkOutput($sformatf("d%0d ready cyc%0d", i, cyc), 32'(ready[i]), 32'(rdyExp));
        if (ready[i] === 1'b1) begin
          lastReadyCyc[i] = cyc;
          lastRdata[i]    = rdata[i];
          lastErr[i]      = err[i];
        end
        if (rdyExp) begin
          checkOutput($sformatf("d%0d err cyc%0d", i, cyc), 32'(err[i]), 32'(expErr[i]));
          if (expKnown[i]) begin
            checkOutput($sformatf("d%0d rdata cyc%0d", i, cyc), rdata[i], expRdata[i]);
          end else begin
            modelMem[i][learnIdx[i]]   = rdata[i];
            modelKnown[i][learnIdx[i]] = 1'b1;
          end
        end else begin
          checkOutput($sformatf("d%0d err idle cyc%0d", i, cyc), 32'(err[i]), 32'h0);
        end
      end
    end
  end

  task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] off;
    bit          inR;
    bit          prot;
    int          idx;
    @(posedge clk); #1;
    vld[i] = 1'b1; addr[i] = a; wdata[i] = wd; wstrb[i] = ws;
    lastRdata[i] = 'x; lastErr[i] = 1'bx; lastReadyCyc[i] = -1;
    off  = a - baseOf(i);
    inR  = off < 32'(4 * depthOf(i));
    idx  = inR ? int'(off[31:2]) : 0;
    prot = WPROT && (ws != 4'b0000) && inR && (idx < PROT_WORDS);
    expKnown[i] = 1'b1;
    if (!inR) begin
      expRdata[i] = 32'h0; expErr[i] = 1'b1;
    end else if (ws != 4'b0000) begin
      expRdata[i] = 32'h0; expErr[i] = prot;
      if (!prot) begin
        for (int b = 0; b < 4; b++) if (ws[b]) modelMem[i][idx][8*b +: 8] = wd[8*b +: 8];
        if (ws == 4'b1111) modelKnown[i][idx] = 1'b1;
      end
    end else begin
      expErr[i] = 1'b0;
      if (modelKnown[i][idx]) expRdata[i] = modelMem[i][idx];
      else begin expKnown[i] = 1'b0; learnIdx[i] = idx; end
    end
    issueCyc[i]    = cyc;
    expReadyCyc[i] = cyc + waitOf(i) + 2;
    @(posedge clk); #1;
    addr[i] = ~a; wdata[i] = ~wd; wstrb[i] = ~ws;
    repeat (waitOf(i) + 1) @(posedge clk);
    #1;
    vld[i] = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic checkLast(input int i, input string name, input logic [31:0] rd, input logic e, input int lat);
    checkOutput({name, " rdata"}, lastRdata[i], rd);
    checkOutput({name, " err"}, 32'(lastErr[i]), 32'(e));
    checkOutput({name, " latency"}, 32'(lastReadyCyc[i] - issueCyc[i]), 32'(lat));
  endtask

  // Reset pulse one cycle after the request is taken: the write must never commit.
  task automatic applyAbort(input int i, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    vld[i] = 1'b1; addr[i] = a; wdata[i] = wd; wstrb[i] = 4'b1111;
    @(posedge clk); #1;
    rstn[i] = 1'b0; vld[i] = 1'b0;
    @(posedge clk); #1;
    rstn[i] = 1'b1;
    @(negedge clk); #1;
    checkOutput("d2 rdata after reset", rdata[i], 32'h0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int firstReady;

  initial begin
    for (int i = 0; i < NINST; i++) begin
      rstn[i] = 1'b0; vld[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
      expReadyCyc[i] = -1; lastReadyCyc[i] = -1; expKnown[i] = 1'b1;
      expRdata[i] = '0; expErr[i] = 1'b0; learnIdx[i] = 0; issueCyc[i] = 0;
      for (int w = 0; w < 1024; w++) modelKnown[i][w] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkEn = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < NINST; i++) begin
      checkOutput($sformatf("d%0d reset rdata", i), rdata[i], 32'h0);
      checkOutput($sformatf("d%0d reset ready", i), 32'(ready[i]), 32'h0);
      checkOutput($sformatf("d%0d reset err", i), 32'(err[i]), 32'h0);
      rstn[i] = 1'b1;
    end

    applyStimulus(0, 32'h10, 32'hDEADBEEF, 4'b1111);  checkLast(0, "d0 wr 0x10", 32'h0, 1'b0, 2);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);         checkLast(0, "d0 rd 0x10", 32'hDEADBEEF, 1'b0, 2);
    applyStimulus(0, 32'h12, 32'h00AA0000, 4'b0100);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);         checkLast(0, "d0 rd lane2", 32'hDEAABEEF, 1'b0, 2);
    applyStimulus(0, 32'hFFC, 32'h11223344, 4'b1111);
    applyStimulus(0, 32'h1010, 32'h55667788, 4'b1111); checkLast(0, "d0 wr oor top", 32'h0, 1'b1, 2);
    applyStimulus(0, 32'hFFFFFFFC, 32'h99999999, 4'b1111); checkLast(0, "d0 wr oor wrap", 32'h0, 1'b1, 2);
    applyStimulus(0, 32'h1000, 32'h0, 4'b0000);       checkLast(0, "d0 rd oor top", 32'h0, 1'b1, 2);
    applyStimulus(0, 32'hFFFFFFFC, 32'h0, 4'b0000);   checkLast(0, "d0 rd oor wrap", 32'h0, 1'b1, 2);
    applyStimulus(0, 32'h10, 32'h0, 4'b0000);         checkLast(0, "d0 rd 0x10 kept", 32'hDEAABEEF, 1'b0, 2);
    applyStimulus(0, 32'hFFC, 32'h0, 4'b0000);        checkLast(0, "d0 rd 0xFFC kept", 32'h11223344, 1'b0, 2);
    applyStimulus(0, 32'h80, 32'h01020304, 4'b1111);
    applyStimulus(0, 32'h81, 32'hA5A5A5A5, 4'b1001);
    applyStimulus(0, 32'h80, 32'h0, 4'b0000);         checkLast(0, "d0 rd strb1001", 32'hA50203A5, 1'b0, 2);
    applyStimulus(0, 32'h0, 32'h0, 4'b0000);
    applyStimulus(0, 32'h0, 32'hFFFFFFFF, 4'b1111);   checkLast(0, "d0 wr word0", 32'h0, WPROT, 2);
    applyStimulus(0, 32'h0, 32'h0, 4'b0000);
    checkLast(0, "d0 rd word0", WPROT ? modelMem[0][0] : 32'hFFFFFFFF, 1'b0, 2);
    applyStimulus(0, 32'h40, 32'h0BADC0DE, 4'b1111);  checkLast(0, "d0 wr word16", 32'h0, 1'b0, 2);
    applyStimulus(0, 32'h40, 32'h0, 4'b0000);         checkLast(0, "d0 rd word16", 32'h0BADC0DE, 1'b0, 2);

    applyStimulus(1, 32'h1F0, 32'hCAFEBABE, 4'b1111); checkLast(1, "d1 wr", 32'h0, 1'b0, 5);
    applyStimulus(1, 32'h1F0, 32'h0, 4'b0000);        checkLast(1, "d1 rd first", 32'hCAFEBABE, 1'b0, 5);
    firstReady = lastReadyCyc[1];
    applyStimulus(1, 32'h1F2, 32'h0, 4'b0000);        checkLast(1, "d1 rd b2b", 32'hCAFEBABE, 1'b0, 5);
    checkOutput("d1 b2b ready gap", 32'(lastReadyCyc[1] - firstReady), 32'd6);
    applyStimulus(1, 32'h200, 32'h0, 4'b0000);        checkLast(1, "d1 rd oor top", 32'h0, 1'b1, 5);
    applyStimulus(1, 32'hFC, 32'h0, 4'b0000);         checkLast(1, "d1 rd below base", 32'h0, 1'b1, 5);
    applyStimulus(1, 32'h2F0, 32'hFFFFFFFF, 4'b1111); checkLast(1, "d1 wr oor alias", 32'h0, 1'b1, 5);
    applyStimulus(1, 32'h1F0, 32'h0, 4'b0000);        checkLast(1, "d1 rd kept", 32'hCAFEBABE, 1'b0, 5);

    applyStimulus(2, 32'h20, 32'hCAFEF00D, 4'b1111);
    applyStimulus(2, 32'h20, 32'h0, 4'b0000);         checkLast(2, "d2 rd before abort", 32'hCAFEF00D, 1'b0, 4);
    applyAbort(2, 32'h20, 32'h12345678);
    applyStimulus(2, 32'h20, 32'h0, 4'b0000);         checkLast(2, "d2 rd after abort", 32'hCAFEF00D, 1'b0, 4);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
